stopwatch_core: RTL and testbench

Parametrised stopwatch/timer datapath and control. It replaces the fixed two-digit count-up stopwatch with a configurable design:
- N-digit BCD count, selectable up or down counting with preset load;
- prescaler that survives pause;
- split hold;
- circular lap stash with overwrite-oldest.

It sits between the button debouncers (all inputs are already single-cycle pulses) and the 7-segment display driver.

---
 rtl/stopwatch_core.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// Stopwatch/timer core: N-digit BCD up/down count with preset, pausable prescaler,
// split hold and a circular lap stash that overwrites its oldest entry when full.
module stopwatch_core #(
  parameter int CLK_FREQ    = 100000000,
  parameter int TICK_CYCLES = 10000000,
  parameter int DIGITS      = 4,
  parameter int LAP_DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start_stop,
  input  logic                           clear,
  input  logic                           split,
  input  logic                           count_down,
  input  logic                           load,
  input  logic [4*DIGITS-1:0]            preset,
  input  logic                           lap_store,
  input  logic                           lap_next,
  input  logic                           lap_clear,
  output logic [4*DIGITS-1:0]            display,
  output logic [4*DIGITS-1:0]            lap_out,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_overflow,
  output logic                           running,
  output logic                           split_active,
  output logic                           expired,
  output logic                           rollover
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int NW = $clog2(LAP_DEPTH + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX   = AW'(LAP_DEPTH - 1);
  localparam logic [NW-1:0] FULL_CNT   = NW'(LAP_DEPTH);

  if (LAP_DEPTH < 2 || DIGITS < 1 || TICK_CYCLES < 1 || CLK_FREQ < 1) begin : g_param_check
    $error("stopwatch_core: invalid parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_EXPIRED
  } state_e;

  function automatic logic [CW-1:0] all_nines();
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  localparam logic [CW-1:0] ALL_NINES = all_nines();

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? LAST_IDX : p - AW'(1);
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] preset_q, preset_d;
  logic          mode_down_q, mode_down_d;
  logic [CW-1:0] split_q, split_d;
  logic          split_active_q, split_active_d;
  logic [CW-1:0] display_q, display_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          rollover_q, rollover_d;

  logic [CW-1:0] stash_q [LAP_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] lap_count_q, lap_count_d;
  logic          lap_overflow_q, lap_overflow_d;
  logic [CW-1:0] lap_out_q, lap_out_d;
  logic          lap_we;
  logic [AW-1:0] oldest_idx;

  always_comb begin
    // NOTE: every *_d gets its hold value first so no branch leaves one unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    count_d        = count_q;
    presc_d        = presc_q;
    preset_d       = preset_q;
    mode_down_d    = mode_down_q;
    split_d        = split_q;
    split_active_d = split_active_q;
    expired_d      = 1'b0;
    rollover_d     = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      count_d = mode_down_q ? preset_q : '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          mode_down_d = count_down;
          presc_d     = '0;
          if (load) begin
            preset_d = bcd_clamp(preset);
            count_d  = bcd_clamp(preset);
          end
          if (start_stop && !(count_down && count_d == '0)) state_d = ST_RUNNING;
        end
        ST_RUNNING: begin
          // The tick is processed even on the pausing cycle, so the fraction resumes exactly.
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (mode_down_q) begin
              count_d = bcd_dec(count_q);
              if (count_d == '0) begin
                state_d   = ST_EXPIRED;
                expired_d = 1'b1;
              end
            end else begin
              count_d    = bcd_inc(count_q);
              rollover_d = (count_q == ALL_NINES);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          if (split) begin
            split_active_d = !split_active_q;
            if (!split_active_q) split_d = count_q;
          end
          if (start_stop && state_d == ST_RUNNING) state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (start_stop) state_d = ST_RUNNING;
        end
        ST_EXPIRED: begin
          count_d = '0;
          if (start_stop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != ST_RUNNING) split_active_d = 1'b0;
    running_d = (state_d == ST_RUNNING);
    display_d = split_active_d ? split_d : count_d;
  end

  // Without wrap-around the oldest entry is slot 0; once full it sits at the write pointer.
  assign oldest_idx = (lap_count_q == FULL_CNT) ? wr_ptr_q : '0;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    lap_count_d    = lap_count_q;
    lap_overflow_d = lap_overflow_q;
    lap_we         = 1'b0;

    if (lap_clear) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      lap_count_d    = '0;
      lap_overflow_d = 1'b0;
    end else if (lap_store) begin
      lap_we   = 1'b1;
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = ptr_inc(wr_ptr_q);
      if (lap_count_q == FULL_CNT) lap_overflow_d = 1'b1;
      else                         lap_count_d    = lap_count_q + NW'(1);
    end else if (lap_next && lap_count_q != '0) begin
      rd_ptr_d = (rd_ptr_q == oldest_idx) ? ptr_dec(wr_ptr_q) : ptr_dec(rd_ptr_q);
    end

    if (lap_count_d == '0) lap_out_d = '0;
    else if (lap_we)       lap_out_d = count_q;
    else                   lap_out_d = stash_q[rd_ptr_d];
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // independent of the order of statements in this block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      presc_q        <= '0;
      preset_q       <= '0;
      mode_down_q    <= 1'b0;
      split_q        <= '0;
      split_active_q <= 1'b0;
      display_q      <= '0;
      running_q      <= 1'b0;
      expired_q      <= 1'b0;
      rollover_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      lap_count_q    <= '0;
      lap_overflow_q <= 1'b0;
      lap_out_q      <= '0;
      // NOTE: the stash is deliberately reset so no stale lap survives a reset;
      // this forces it into flops rather than a RAM macro.
      for (int i = 0; i < LAP_DEPTH; i++) stash_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      presc_q        <= presc_d;
      preset_q       <= preset_d;
      mode_down_q    <= mode_down_d;
      split_q        <= split_d;
      split_active_q <= split_active_d;
      display_q      <= display_d;
      running_q      <= running_d;
      expired_q      <= expired_d;
      rollover_q     <= rollover_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      lap_count_q    <= lap_count_d;
      lap_overflow_q <= lap_overflow_d;
      lap_out_q      <= lap_out_d;
      if (lap_we) stash_q[wr_ptr_q] <= count_q;
    end
  end

  assign display      = display_q;
  assign lap_out      = lap_out_q;
  assign lap_count    = lap_count_q;
  assign lap_overflow = lap_overflow_q;
  assign running      = running_q;
  assign split_active = split_active_q;
  assign expired      = expired_q;
  assign rollover     = rollover_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: expectations are queued with the stimulus
// (stamped with the cycle they are due) and popped when the outputs are sampled.
module tb_stopwatch_core;

  localparam int TICK   = 4;
  localparam int DIGITS = 2;
  localparam int DEPTH  = 3;
  localparam int CW     = 4 * DIGITS;
  localparam int NW     = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_stop = 1'b0, clear = 1'b0, split = 1'b0, count_down = 1'b0, load = 1'b0;
  logic lap_store = 1'b0, lap_next = 1'b0, lap_clear = 1'b0;
  logic [CW-1:0] preset = '0;
  logic [CW-1:0] display, lap_out;
  logic [NW-1:0] lap_count;
  logic          lap_overflow, running, split_active, expired, rollover;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [7:0]  disp;
    logic        run;
    logic        xp;
    logic        roll;
    logic        spl;
  } obs_exp_t;

  typedef struct {
    int          cyc;
    string       tag;
    logic [7:0]  out;
    logic [1:0]  cnt;
    logic        ovf;
  } lap_exp_t;

  obs_exp_t sb[$];
  lap_exp_t lsb[$];

  stopwatch_core #(
    .CLK_FREQ   (100),
    .TICK_CYCLES(TICK),
    .DIGITS     (DIGITS),
    .LAP_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_stop  (start_stop),
    .clear       (clear),
    .split       (split),
    .count_down  (count_down),
    .load        (load),
    .preset      (preset),
    .lap_store   (lap_store),
    .lap_next    (lap_next),
    .lap_clear   (lap_clear),
    .display     (display),
    .lap_out     (lap_out),
    .lap_count   (lap_count),
    .lap_overflow(lap_overflow),
    .running     (running),
    .split_active(split_active),
    .expired     (expired),
    .rollover    (rollover)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_obs(input int cyc, input string tag, input logic [7:0] d,
                          input logic r, input logic x, input logic ro, input logic s);
    obs_exp_t e;
    e.cyc = cyc; e.tag = tag; e.disp = d; e.run = r; e.xp = x; e.roll = ro; e.spl = s;
    sb.push_back(e);
  endtask

  task automatic push_lap(input int cyc, input string tag, input logic [7:0] o,
                          input logic [1:0] c, input logic v);
    lap_exp_t e;
    e.cyc = cyc; e.tag = tag; e.out = o; e.cnt = c; e.ovf = v;
    lsb.push_back(e);
  endtask

  task automatic pulse_start();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    preset = v; load = 1'b1; step(1); load = 1'b0;
  endtask

  task automatic test_reset();
    obs_exp_t e;
    lap_exp_t l;
    push_obs(0, "reset_outputs", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    push_lap(0, "reset_stash", 8'h00, 2'd0, 1'b0);
    reset_n = 1'b0; start_stop = 1'b1; lap_store = 1'b1; preset = 8'hFF;
    step(2);
    start_stop = 1'b0; lap_store = 1'b0; preset = '0;
    e = sb.pop_front(); vectors++;
    if ({display, running, expired, rollover, split_active} !== {e.disp, e.run, e.xp, e.roll, e.spl}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b exp=%b roll=%b split=%b want disp=%h run=%b exp=%b roll=%b split=%b",
               e.tag, display, running, expired, rollover, split_active, e.disp, e.run, e.xp, e.roll, e.spl);
    end
    l = lsb.pop_front(); vectors++;
    if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
      miscompares++;
      $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
               l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
    end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_up_count();
    obs_exp_t e;
    push_obs(3,   "up_before_first_tick", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(4,   "up_first_tick",        8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(40,  "up_carry_to_10",       8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(396, "up_reach_99",          8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(399, "up_hold_99",           8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(400, "up_wrap_rollover",     8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    push_obs(401, "up_rollover_one_cycle", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    for (int c = 1; c <= 401; c++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); vectors++;
        if ({display, running, expired, rollover, split_active} !== {e.disp, e.run, e.xp, e.roll, e.spl}) begin
          miscompares++;
          $display("FAIL %s: got disp=%h run=%b exp=%b roll=%b split=%b want disp=%h run=%b exp=%b roll=%b split=%b",
                   e.tag, display, running, expired, rollover, split_active, e.disp, e.run, e.xp, e.roll, e.spl);
        end
      end
    end
    push_obs(0, "up_clear_to_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    e = sb.pop_front(); vectors++;
    if ({display, running, expired, rollover, split_active} !== {e.disp, e.run, e.xp, e.roll, e.spl}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b want disp=%h run=%b", e.tag, display, running, e.disp, e.run);
    end
  endtask

  task automatic test_pause_fraction();
    obs_exp_t e;
    push_obs(6,  "pause_at_01",        8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    push_obs(26, "pause_frozen",       8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    push_obs(28, "resume_plus_1",      8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(29, "resume_plus_2_step", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    for (int c = 1; c <= 29; c++) begin
      start_stop = (c == 6) || (c == 27);
      step(1);
      start_stop = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); vectors++;
        if ({display, running, expired, rollover, split_active} !== {e.disp, e.run, e.xp, e.roll, e.spl}) begin
          miscompares++;
          $display("FAIL %s: got disp=%h run=%b exp=%b roll=%b split=%b want disp=%h run=%b exp=%b roll=%b split=%b",
                   e.tag, display, running, expired, rollover, split_active, e.disp, e.run, e.xp, e.roll, e.spl);
        end
      end
    end
    pulse_clear();
  endtask

  task automatic test_down_expire();
    obs_exp_t e;
    count_down = 1'b1;
    step(1);
    push_obs(0, "preset_clamp_A7", 8'h97, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_load(8'hA7);
    e = sb.pop_front(); vectors++;
    if (display !== e.disp) begin
      miscompares++;
      $display("FAIL %s: got display=%h want %h", e.tag, display, e.disp);
    end
    pulse_load(8'h00);
    push_obs(0, "down_start_at_zero_ignored", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    e = sb.pop_front(); vectors++;
    if ({display, running} !== {e.disp, e.run}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b want disp=%h run=%b", e.tag, display, running, e.disp, e.run);
    end
    pulse_load(8'h03);
    push_obs(3,  "down_hold_03",      8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(4,  "down_02",           8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(8,  "down_01",           8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(11, "down_before_zero",  8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(12, "down_expired",      8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    push_obs(13, "expired_one_cycle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    for (int c = 1; c <= 13; c++) begin
      step(1);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); vectors++;
        if ({display, running, expired, rollover, split_active} !== {e.disp, e.run, e.xp, e.roll, e.spl}) begin
          miscompares++;
          $display("FAIL %s: got disp=%h run=%b exp=%b roll=%b split=%b want disp=%h run=%b exp=%b roll=%b split=%b",
                   e.tag, display, running, expired, rollover, split_active, e.disp, e.run, e.xp, e.roll, e.spl);
        end
      end
    end
    push_obs(0, "down_clear_restores_preset", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    e = sb.pop_front(); vectors++;
    if ({display, running, expired} !== {e.disp, e.run, e.xp}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b exp=%b want disp=%h run=%b exp=%b",
               e.tag, display, running, expired, e.disp, e.run, e.xp);
    end
    count_down = 1'b0;
    step(1);
    push_obs(0, "up_clear_zero", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    e = sb.pop_front(); vectors++;
    if (display !== e.disp) begin
      miscompares++;
      $display("FAIL %s: got display=%h want %h", e.tag, display, e.disp);
    end
  endtask

  task automatic test_split();
    obs_exp_t e;
    lap_exp_t l;
    push_obs(20, "split_live_05",       8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(21, "split_capture_05",    8'h05, 1'b1, 1'b0, 1'b0, 1'b1);
    push_obs(25, "split_hold_live_06",  8'h05, 1'b1, 1'b0, 1'b0, 1'b1);
    push_obs(34, "split_hold_live_08",  8'h05, 1'b1, 1'b0, 1'b0, 1'b1);
    push_obs(35, "split_release",       8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(36, "split_tracks_live",   8'h09, 1'b1, 1'b0, 1'b0, 1'b0);
    push_obs(37, "split_recapture_09",  8'h09, 1'b1, 1'b0, 1'b0, 1'b1);
    push_obs(38, "pause_drops_split",   8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
    push_lap(34, "lap_stores_live_not_split", 8'h08, 2'd1, 1'b0);
    pulse_start();
    for (int c = 1; c <= 38; c++) begin
      split      = (c == 21) || (c == 35) || (c == 37);
      lap_store  = (c == 34);
      start_stop = (c == 38);
      step(1);
      split = 1'b0; lap_store = 1'b0; start_stop = 1'b0;
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); vectors++;
        if ({display, running, expired, rollover, split_active} !== {e.disp, e.run, e.xp, e.roll, e.spl}) begin
          miscompares++;
          $display("FAIL %s: got disp=%h run=%b exp=%b roll=%b split=%b want disp=%h run=%b exp=%b roll=%b split=%b",
                   e.tag, display, running, expired, rollover, split_active, e.disp, e.run, e.xp, e.roll, e.spl);
        end
      end
      while (lsb.size() > 0 && lsb[0].cyc == c) begin
        l = lsb.pop_front(); vectors++;
        if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
          miscompares++;
          $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
                   l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
        end
      end
    end
    pulse_clear();
    push_lap(0, "lap_clear_empties", 8'h00, 2'd0, 1'b0);
    lap_clear = 1'b1; step(1); lap_clear = 1'b0;
    l = lsb.pop_front(); vectors++;
    if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
      miscompares++;
      $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
               l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
    end
  endtask

  task automatic test_lap_overflow();
    lap_exp_t   l;
    logic [7:0] vals [4];
    logic [7:0] walk [3];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    walk = '{8'h33, 8'h22, 8'h44};
    for (int i = 0; i < 4; i++) begin
      push_lap(0, $sformatf("store_%0d", i), vals[i], (i < DEPTH) ? 2'(i + 1) : 2'(DEPTH), i >= DEPTH);
      pulse_load(vals[i]);
      lap_store = 1'b1; step(1); lap_store = 1'b0;
      l = lsb.pop_front(); vectors++;
      if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
        miscompares++;
        $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
                 l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
      end
    end
    for (int i = 0; i < 3; i++) begin
      push_lap(0, $sformatf("lap_next_%0d", i), walk[i], 2'(DEPTH), 1'b1);
      lap_next = 1'b1; step(1); lap_next = 1'b0;
      l = lsb.pop_front(); vectors++;
      if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
        miscompares++;
        $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
                 l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
      end
    end
  endtask

  task automatic test_simultaneous();
    obs_exp_t e;
    lap_exp_t l;
    pulse_load(8'h55);
    push_lap(0, "store_beats_next", 8'h55, 2'd3, 1'b1);
    lap_store = 1'b1; lap_next = 1'b1; step(1); lap_store = 1'b0; lap_next = 1'b0;
    l = lsb.pop_front(); vectors++;
    if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
      miscompares++;
      $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
               l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
    end
    push_lap(0, "next_after_store", 8'h44, 2'd3, 1'b1);
    lap_next = 1'b1; step(1); lap_next = 1'b0;
    l = lsb.pop_front(); vectors++;
    if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
      miscompares++;
      $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
               l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
    end
    push_lap(0, "lap_clear_beats_store", 8'h00, 2'd0, 1'b0);
    lap_clear = 1'b1; lap_store = 1'b1; step(1); lap_clear = 1'b0; lap_store = 1'b0;
    l = lsb.pop_front(); vectors++;
    if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
      miscompares++;
      $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
               l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
    end
    pulse_start();
    step(2);
    push_obs(0, "clear_beats_start_stop", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    push_obs(5, "idle_stays_frozen",      8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
    e = sb.pop_front(); vectors++;
    if ({display, running, split_active} !== {e.disp, e.run, e.spl}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b split=%b want disp=%h run=%b split=%b",
               e.tag, display, running, split_active, e.disp, e.run, e.spl);
    end
    step(5);
    e = sb.pop_front(); vectors++;
    if ({display, running} !== {e.disp, e.run}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b want disp=%h run=%b", e.tag, display, running, e.disp, e.run);
    end
  endtask

  task automatic test_reset_mid_run();
    obs_exp_t e;
    lap_exp_t l;
    pulse_load(8'h12);
    lap_store = 1'b1; step(1); lap_store = 1'b0;
    push_obs(0, "pre_reset_running", 8'h13, 1'b1, 1'b0, 1'b0, 1'b0);
    push_lap(0, "pre_reset_stash",   8'h12, 2'd1, 1'b0);
    pulse_start();
    step(5);
    e = sb.pop_front(); vectors++;
    if ({display, running} !== {e.disp, e.run}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b want disp=%h run=%b", e.tag, display, running, e.disp, e.run);
    end
    l = lsb.pop_front(); vectors++;
    if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
      miscompares++;
      $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
               l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
    end
    push_obs(0, "mid_run_reset_outputs", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    push_lap(0, "mid_run_reset_stash",   8'h00, 2'd0, 1'b0);
    reset_n = 1'b0; start_stop = 1'b1; lap_store = 1'b1; split = 1'b1;
    step(1);
    start_stop = 1'b0; lap_store = 1'b0; split = 1'b0;
    e = sb.pop_front(); vectors++;
    if ({display, running, expired, rollover, split_active} !== {e.disp, e.run, e.xp, e.roll, e.spl}) begin
      miscompares++;
      $display("FAIL %s: got disp=%h run=%b exp=%b roll=%b split=%b want disp=%h run=%b exp=%b roll=%b split=%b",
               e.tag, display, running, expired, rollover, split_active, e.disp, e.run, e.xp, e.roll, e.spl);
    end
    l = lsb.pop_front(); vectors++;
    if ({lap_out, lap_count, lap_overflow} !== {l.out, l.cnt, l.ovf}) begin
      miscompares++;
      $display("FAIL %s: got lap_out=%h cnt=%0d ovf=%b want lap_out=%h cnt=%0d ovf=%b",
               l.tag, lap_out, lap_count, lap_overflow, l.out, l.cnt, l.ovf);
    end
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_pause_fraction();
    test_down_expire();
    test_split();
    test_lap_overflow();
    test_simultaneous();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
